// File: rtl/load_ins_dispatcher_pkg.sv
// Shared LOAD instruction format: opcode and field positions of the 96-bit word.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package load_ins_dispatcher_pkg;

  localparam int INS_LEN_P = 96;

  // Opcode carried in the instruction header nibble.
  localparam logic [3:0] HEAD_LOAD = 4'b0001;

  // Field positions, shared with the load parser so both sides agree on the layout.
  localparam int DDR_MSB       = 95;
  localparam int DDR_LSB       = 64;
  localparam int IWB_MSB       = 63;
  localparam int IWB_LSB       = 62;
  localparam int LINE_MSB      = 61;
  localparam int LINE_LSB      = 50;
  localparam int TOTAL_MSB     = 49;
  localparam int TOTAL_LSB     = 34;
  localparam int ZF_BIT        = 33;
  localparam int OPX_BIT       = 32;  // reserved, always 0
  localparam int HEAD_MSB      = 31;
  localparam int HEAD_LSB      = 28;
  localparam int RSV_MSB       = 27;  // reserved, always 0
  localparam int RSV_LSB       = 20;
  localparam int BANK_MSB      = 19;
  localparam int BANK_LSB      = 12;
  localparam int BANK_ADDR_MSB = 11;
  localparam int BANK_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ACK       = 2'd3
  } disp_state_t;

endpackage

// File: rtl/load_ins_dispatcher_fifo.sv
// Command queue of packed instructions with a registered read stage (show-ahead word in rd_dat).
// Latency: a word pushed at edge k is presented on rd_dat/rd_vld after edge k+1.
// Backpressure: full asserts when DEPTH words are held (storage plus read stage); push must not be issued while full.
// Ports: clk, rst_n | push, push_dat | pop (acts only when rd_vld) | rd_dat, rd_vld | full, empty (total occupancy)
module ins_cmd_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] rd_dat,
  output logic         rd_vld,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] mem_cnt;   // words in storage, excluding the read stage
  logic [CW-1:0] tot_cnt;   // words in storage plus the read stage
  logic [W-1:0]  out_dat;
  logic          out_vld;
  logic          pop_eff;
  logic          load_out;

  assign pop_eff  = pop && out_vld;
  // Refill the read stage whenever it is empty or being consumed this cycle.
  assign load_out = (mem_cnt != '0) && (!out_vld || pop_eff);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      tot_cnt <= '0;
      out_dat <= '0;
      out_vld <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load_out) begin
        out_dat <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
        out_vld <= 1'b1;
      end else if (pop_eff) begin
        out_vld <= 1'b0;
      end
      mem_cnt <= mem_cnt + CW'(push) - CW'(load_out);
      tot_cnt <= tot_cnt + CW'(push) - CW'(pop_eff);
    end
  end

  assign rd_dat = out_dat;
  assign rd_vld = out_vld;
  assign full   = (tot_cnt == CW'(DEPTH));
  assign empty  = (tot_cnt == '0);

endmodule

// File: rtl/load_ins_dispatcher.sv
// Packs scheduler load commands into LOAD instructions, issues one at a time and acknowledges parser completion.
// Latency: command pushed at edge k into an idle, empty block drives ins_valid after edge k+2; ack one cycle after ins_done.
// Backpressure: cmd_ready drops while the queue is full; ins_data/ins_valid hold until ins_ready.
// Ports: clk, rst_n | cmd_* (valid/ready + fields) | ins_data, ins_valid, ins_ready | ins_done, ins_done_ack
//        | busy, done_cnt, err_timeout (sticky until reset)
module load_ins_dispatcher
  import load_ins_dispatcher_pkg::*;
#(
  parameter int IWB_SEL_W   = 2,
  parameter int BID_W       = 8,
  parameter int ADDR_W      = 12,
  parameter int DDR_ADDR_W  = 32,
  parameter int LINE_SIZE_W = 12,
  parameter int ALL_SIZE_W  = 16,
  parameter int INS_LEN     = INS_LEN_P,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = 16,
  parameter int TMO_W       = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [IWB_SEL_W-1:0]   cmd_iwb_id,
  input  logic [BID_W-1:0]       cmd_bank_id,
  input  logic [ADDR_W-1:0]      cmd_bank_addr,
  input  logic [LINE_SIZE_W-1:0] cmd_line_size,
  input  logic [ALL_SIZE_W-1:0]  cmd_total_size,
  input  logic                   cmd_zero_fill,
  input  logic [DDR_ADDR_W-1:0]  cmd_ddr_addr,
  output logic [INS_LEN-1:0]     ins_data,
  output logic                   ins_valid,
  input  logic                   ins_ready,
  input  logic                   ins_done,
  output logic                   ins_done_ack,
  output logic                   busy,
  output logic [CNT_W-1:0]       done_cnt,
  output logic                   err_timeout
);

  disp_state_t        state;
  disp_state_t        state_nxt;
  logic [INS_LEN-1:0] ins_word;
  logic [INS_LEN-1:0] ins_data_q;
  logic [INS_LEN-1:0] fifo_rd_dat;
  logic               fifo_rd_vld;
  logic               fifo_full;
  logic               fifo_empty;
  logic               cmd_push;
  logic               fifo_pop;
  logic               load_ins;
  logic               xfer;
  logic [TMO_W-1:0]   wdog;
  logic [TMO_W-1:0]   wdog_inc;
  logic [CNT_W-1:0]   done_cnt_q;
  logic               err_q;

  // Pack the command into the instruction word; reserved bits stay zero.
  always_comb begin
    ins_word                              = '0;
    ins_word[DDR_MSB:DDR_LSB]             = cmd_ddr_addr;
    ins_word[IWB_MSB:IWB_LSB]             = cmd_iwb_id;
    ins_word[LINE_MSB:LINE_LSB]           = cmd_line_size;
    ins_word[TOTAL_MSB:TOTAL_LSB]         = cmd_total_size;
    ins_word[ZF_BIT]                      = cmd_zero_fill;
    ins_word[HEAD_MSB:HEAD_LSB]           = HEAD_LOAD;
    ins_word[BANK_MSB:BANK_LSB]           = cmd_bank_id;
    ins_word[BANK_ADDR_MSB:BANK_ADDR_LSB] = cmd_bank_addr;
  end

  assign cmd_ready = !fifo_full;
  assign cmd_push  = cmd_valid && cmd_ready;

  ins_cmd_fifo #(
    .W     (INS_LEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cmd_push),
    .push_dat (ins_word),
    .pop      (fifo_pop),
    .rd_dat   (fifo_rd_dat),
    .rd_vld   (fifo_rd_vld),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ins_done outside WAIT_DONE is deliberately not looked at.
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    load_ins  = 1'b0;
    xfer      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fifo_rd_vld) begin
          fifo_pop  = 1'b1;
          load_ins  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ins_ready) begin
          xfer      = 1'b1;
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (ins_done) begin
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign wdog_inc = wdog + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_data_q <= '0;
      wdog       <= '0;
      done_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (load_ins) begin
        ins_data_q <= fifo_rd_dat;
      end
      if (xfer) begin
        wdog <= '0;
      end else if (state == ST_WAIT_DONE && !(&wdog)) begin
        wdog <= wdog_inc;
        // Flag on the cycle the counter reaches all-ones, then hold it there.
        if (&wdog_inc) begin
          err_q <= 1'b1;
        end
      end
      if (state == ST_ACK) begin
        done_cnt_q <= done_cnt_q + 1'b1;
      end
    end
  end

  assign ins_data     = ins_data_q;
  assign ins_valid    = (state == ST_ISSUE);
  assign ins_done_ack = (state == ST_ACK);
  assign busy         = !fifo_empty || (state != ST_IDLE);
  assign done_cnt     = done_cnt_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_load_ins_dispatcher.sv
module tb_load_ins_dispatcher;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_iwb_id;
  logic [7:0]  cmd_bank_id;
  logic [11:0] cmd_bank_addr;
  logic [11:0] cmd_line_size;
  logic [15:0] cmd_total_size;
  logic        cmd_zero_fill;
  logic [31:0] cmd_ddr_addr;
  logic [95:0] ins_data;
  logic        ins_valid;
  logic        ins_ready;
  logic        ins_done;
  logic        ins_done_ack;
  logic        busy;
  logic [15:0] done_cnt;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = '0;

  // Hand-packed words for the two field patterns used below.
  localparam logic [95:0] EXP1 = 96'h80001000_81001000_10005010;
  localparam logic [63:0] LOW1 = 64'h81001000_10005010;
  localparam logic [95:0] EXP3 = 96'hDEADBEEF_7FFFFFFE_100A5FFF;

  load_ins_dispatcher #(
    .FIFO_DEPTH (4),
    .TMO_W      (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_iwb_id     (cmd_iwb_id),
    .cmd_bank_id    (cmd_bank_id),
    .cmd_bank_addr  (cmd_bank_addr),
    .cmd_line_size  (cmd_line_size),
    .cmd_total_size (cmd_total_size),
    .cmd_zero_fill  (cmd_zero_fill),
    .cmd_ddr_addr   (cmd_ddr_addr),
    .ins_data       (ins_data),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins_done       (ins_done),
    .ins_done_ack   (ins_done_ack),
    .busy           (busy),
    .done_cnt       (done_cnt),
    .err_timeout    (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd1(input logic [31:0] ddr);
    cmd_ddr_addr   = ddr;
    cmd_iwb_id     = 2'd2;
    cmd_bank_id    = 8'h05;
    cmd_bank_addr  = 12'h010;
    cmd_line_size  = 12'd64;
    cmd_total_size = 16'd1024;
    cmd_zero_fill  = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ins_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; ins_ready = 1'b0; ins_done = 1'b0;
    set_cmd1(32'h0);
    repeat (2) tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset_ins_valid got %b want 0", ins_valid); end
    checks++; if (ins_data !== 96'h0) begin errors++; $display("FAIL reset_ins_data got %h want 0", ins_data); end
    checks++; if (ins_done_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ins_done_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done_cnt !== 16'h0) begin errors++; $display("FAIL reset_done_cnt got %0d want 0", done_cnt); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_timeout); end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_cmd1(32'h8000_1000);
    cmd_valid = 1'b1;
    tick();  // push edge k
    cmd_valid = 1'b0;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL single_valid_k got %b want 0", ins_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_k got %b want 1", busy); end
    tick();
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL single_valid_k1 got %b want 0", ins_valid); end
    tick();
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL single_valid_k2 got %b want 1", ins_valid); end
    checks++; if (ins_data !== EXP1) begin errors++; $display("FAIL single_data got %h want %h", ins_data, EXP1); end
    checks++; if (ins_data[31:28] !== 4'b0001) begin errors++; $display("FAIL single_head got %b want 0001", ins_data[31:28]); end
    checks++; if (ins_data[63:62] !== 2'd2) begin errors++; $display("FAIL single_iwb got %0d want 2", ins_data[63:62]); end
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b want 0", ins_valid); end
    repeat (2) tick();
    checks++; if (ins_done_ack !== 1'b0) begin errors++; $display("FAIL single_early_ack got %b want 0", ins_done_ack); end
    ins_done = 1'b1;
    tick();
    ins_done = 1'b0;
    checks++; if (ins_done_ack !== 1'b1) begin errors++; $display("FAIL single_ack got %b want 1", ins_done_ack); end
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL single_cnt_during_ack got %0d want 0", done_cnt); end
    tick();
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (ins_done_ack !== 1'b0) begin errors++; $display("FAIL single_ack_pulse got %b want 0", ins_done_ack); end
    checks++; if (done_cnt !== exp_cnt) begin errors++; $display("FAIL single_cnt got %0d want %0d", done_cnt, exp_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [95:0] exp;
    bit ok;
    ins_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cmd1(32'h1000_0000 + 32'(i));
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %b want 1", i, cmd_ready); end
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %b want 0", cmd_ready); end
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_issue got %b want 1", ins_valid); end
    repeat (3) tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_hold got %b want 0", cmd_ready); end
    for (int j = 0; j < 5; j++) begin
      exp = {32'h1000_0000 + 32'(j), LOW1};
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout_%0d got no ins_valid want ins_valid", j); end
      checks++; if (ins_data !== exp) begin errors++; $display("FAIL b2b_data_%0d got %h want %h", j, ins_data, exp); end
      ins_ready = 1'b1;
      tick();
      ins_ready = 1'b0;
      ins_done = 1'b1;
      tick();
      ins_done = 1'b0;
      checks++; if (ins_done_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_%0d got %b want 1", j, ins_done_ack); end
      tick();
      exp_cnt = exp_cnt + 1'b1;
    end
    tick();
    checks++; if (done_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt got %0d want %0d", done_cnt, exp_cnt); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", busy); end
  endtask

  task automatic test_stall();
    bit ok;
    cmd_ddr_addr = 32'hDEAD_BEEF; cmd_iwb_id = 2'd1; cmd_bank_id = 8'hA5; cmd_bank_addr = 12'hFFF;
    cmd_line_size = 12'hFFF; cmd_total_size = 16'hFFFF; cmd_zero_fill = 1'b1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got no ins_valid want ins_valid"); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d got %b want 1", k, ins_valid); end
      checks++; if (ins_data !== EXP3) begin errors++; $display("FAIL stall_data_%0d got %h want %h", k, ins_data, EXP3); end
      ins_done = (k == 4);  // spurious done while still in ISSUE
      tick();
    end
    ins_done = 1'b0;
    checks++; if (ins_done_ack !== 1'b0) begin errors++; $display("FAIL stall_spurious_ack got %b want 0", ins_done_ack); end
    ins_ready = 1'b1;
    tick();
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL stall_xfer got %b want 0", ins_valid); end
    repeat (2) tick();
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL stall_second_xfer got %b want 0", ins_valid); end
    ins_ready = 1'b0;
    ins_done = 1'b1;
    tick();
    ins_done = 1'b0;
    checks++; if (ins_done_ack !== 1'b1) begin errors++; $display("FAIL stall_ack got %b want 1", ins_done_ack); end
    tick();
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (done_cnt !== exp_cnt) begin errors++; $display("FAIL stall_cnt got %0d want %0d", done_cnt, exp_cnt); end
  endtask

  task automatic test_spurious_done();
    ins_done = 1'b1;
    tick();
    checks++; if (ins_done_ack !== 1'b0) begin errors++; $display("FAIL spur_ack0 got %b want 0", ins_done_ack); end
    tick();
    ins_done = 1'b0;
    checks++; if (ins_done_ack !== 1'b0) begin errors++; $display("FAIL spur_ack1 got %b want 0", ins_done_ack); end
    tick();
    checks++; if (ins_done_ack !== 1'b0) begin errors++; $display("FAIL spur_ack2 got %b want 0", ins_done_ack); end
    checks++; if (done_cnt !== exp_cnt) begin errors++; $display("FAIL spur_cnt got %0d want %0d", done_cnt, exp_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spur_busy got %b want 0", busy); end
  endtask

  task automatic test_ready_early();
    ins_ready = 1'b1;
    set_cmd1(32'h8000_1000);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL early_valid_k1 got %b want 0", ins_valid); end
    tick();
    checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL early_valid_k2 got %b want 1", ins_valid); end
    tick();
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL early_xfer got %b want 0", ins_valid); end
    ins_ready = 1'b0;
    ins_done = 1'b1;
    tick();
    ins_done = 1'b0;
    checks++; if (ins_done_ack !== 1'b1) begin errors++; $display("FAIL early_ack got %b want 1", ins_done_ack); end
    tick();
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (done_cnt !== exp_cnt) begin errors++; $display("FAIL early_cnt got %0d want %0d", done_cnt, exp_cnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    set_cmd1(32'h8000_2000);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_issue got no ins_valid want ins_valid"); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_pre got %b want 0", err_timeout); end
    ins_ready = 1'b1;
    tick();  // enters WAIT_DONE, watchdog at 0
    ins_ready = 1'b0;
    repeat (14) tick();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_14 got %b want 0", err_timeout); end
    tick();
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_15 got %b want 1", err_timeout); end
    repeat (5) tick();
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b want 1", err_timeout); end
    checks++; if (ins_done_ack !== 1'b0) begin errors++; $display("FAIL tmo_noack got %b want 0", ins_done_ack); end
    ins_done = 1'b1;
    tick();
    ins_done = 1'b0;
    checks++; if (ins_done_ack !== 1'b1) begin errors++; $display("FAIL tmo_ack got %b want 1", ins_done_ack); end
    tick();
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (done_cnt !== exp_cnt) begin errors++; $display("FAIL tmo_cnt got %0d want %0d", done_cnt, exp_cnt); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_after_ack got %b want 1", err_timeout); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    ins_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd1(32'h2000_0000 + 32'(i));
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    wait_valid(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_issue got no ins_valid want ins_valid"); end
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got %b want 1", busy); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", ins_valid); end
    checks++; if (ins_done_ack !== 1'b0) begin errors++; $display("FAIL rmid_ack got %b want 0", ins_done_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL rmid_cnt got %0d want 0", done_cnt); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", cmd_ready); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rmid_err got %b want 0", err_timeout); end
    checks++; if (ins_data !== 96'h0) begin errors++; $display("FAIL rmid_data got %h want 0", ins_data); end
    #2 rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rmid_lost_valid got %b want 0", ins_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_lost_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_spurious_done();
    test_ready_early();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
